axi_rchan_ctrl: RTL and testbench

- Drains the 64-bit read-data FIFO on the AXI clock side of the bridge and presents the data as AXI read-channel beats (RVALID/RDATA/RID/RRESP/RLAST).
- Takes one burst command per AXI read (ID, length, error flag) from the read-address path and counts beats to generate RLAST.
- Single registered output stage; sustains one beat per cycle under continuous RREADY.

---
 rtl/bridge_pkg.sv | 18 +
 rtl/rchan_out_reg.sv | 58 +++++
 rtl/axi_rchan_ctrl.sv | 111 +++++++++++
 tb/tb_axi_rchan_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the AHB-to-AXI bridge read path.
// Holds response codes, read-channel state encoding and default widths.
package bridge_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_LEN_WIDTH  = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    LAST  = 2'd2
  } rchan_state_e;

endpackage

// File: rtl/rchan_out_reg.sv
// AXI R-channel holding register: loads a new beat, holds it under
// backpressure, and drops RVALID once the beat has been accepted.
module rchan_out_reg
  import bridge_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ID_WIDTH-1:0]   id_i,
  input  logic [1:0]            resp_i,
  input  logic                  last_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ID_WIDTH-1:0]   rid_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o
);

  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
    end else if (load_i) begin
      // A load during a handshake replaces the accepted beat with no bubble.
      rvalid_q <= 1'b1;
      rdata_q  <= data_i;
      rid_q    <= id_i;
      rresp_q  <= resp_i;
      rlast_q  <= last_i;
    end else if (clear_i) begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rid_o    = rid_q;
  assign rresp_o  = rresp_q;
  assign rlast_o  = rlast_q;

endmodule

// File: rtl/axi_rchan_ctrl.sv
// AXI read-data channel controller: pops the read-data FIFO one beat at a
// time for each accepted burst command and generates RLAST from a beat count.
module axi_rchan_ctrl
  import bridge_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  rclk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_err,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  busy
);

  // One extra bit so len=255 represents 256 remaining beats.
  localparam int CNT_WIDTH = LEN_WIDTH + 1;

  rchan_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] beats_left_q, beats_left_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic                 err_q, err_d;
  logic                 pop;
  logic                 out_free;
  logic                 handshake;

  assign out_free  = !rvalid || rready;
  assign handshake = rvalid && rready;

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; no latches.
    state_d      = state_q;
    beats_left_d = beats_left_q;
    id_d         = id_q;
    err_d        = err_q;
    pop          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          id_d         = cmd_id;
          err_d        = cmd_err;
          beats_left_d = {1'b0, cmd_len} + CNT_WIDTH'(1);
          state_d      = BURST;
        end
      end
      BURST: begin
        if (!fifo_empty && out_free) begin
          pop          = 1'b1;
          beats_left_d = beats_left_q - CNT_WIDTH'(1);
          if (beats_left_q == CNT_WIDTH'(1)) state_d = LAST;
        end
      end
      LAST: begin
        // Hold off the next command until the final beat is accepted.
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      id_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      id_q         <= id_d;
      err_q        <= err_d;
    end
  end

  assign fifo_read_en = pop && !reset;
  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);

  rchan_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH)
  ) u_out_reg (
    .clk_i    (rclk),
    .reset_i  (reset),
    .load_i   (fifo_read_en),
    .clear_i  (handshake),
    .data_i   (fifo_data),
    .id_i     (id_q),
    .resp_i   (err_q ? RESP_SLVERR : RESP_OKAY),
    .last_i   (beats_left_q == CNT_WIDTH'(1)),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .rid_o    (rid),
    .rresp_o  (rresp),
    .rlast_o  (rlast)
  );

endmodule

// File: tb/tb_axi_rchan_ctrl.sv
// Scoreboard bench for axi_rchan_ctrl: stimulus queues expected beats,
// a negedge monitor compares every R-channel handshake against them.
module tb_axi_rchan_ctrl;

  localparam int DW = 64;
  localparam int IW = 4;
  localparam int LW = 8;

  logic          rclk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [IW-1:0] cmd_id = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_err = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_read_en;
  logic          rvalid;
  logic          rready = 1'b1;
  logic [DW-1:0] rdata;
  logic [IW-1:0] rid;
  logic [1:0]    rresp;
  logic          rlast;
  logic          busy;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] mem[$];
  logic [DW-1:0] push_req[$];
  int            checks = 0;
  int            failures = 0;
  int            pops = 0;
  int            hs_count = 0;
  int            rr_mode = 0;

  axi_rchan_ctrl #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) dut (
    .rclk(rclk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_len(cmd_len), .cmd_err(cmd_err),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_en(fifo_read_en),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
    .rresp(rresp), .rlast(rlast), .busy(busy)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int tag, input int i);
    return {16'hA5A5, 8'(tag), 8'h00, 32'(i + 1)};
  endfunction

  // FIFO model: pops on fifo_read_en, absorbs words queued by the stimulus.
  always @(posedge rclk) begin
    if (reset) begin
      mem.delete();
      push_req.delete();
    end else begin
      if (fifo_read_en && !fifo_empty) begin
        void'(mem.pop_front());
        pops++;
      end
      while (push_req.size() > 0) mem.push_back(push_req.pop_front());
    end
    fifo_empty <= (mem.size() == 0);
    fifo_data  <= (mem.size() == 0) ? '0 : mem[0];
  end

  // RREADY driver: mode 0 always ready, mode 1 repeats 1,0,0.
  initial begin
    int phase = 0;
    forever begin
      @(posedge rclk);
      #1;
      if (rr_mode == 0) rready = 1'b1;
      else rready = (phase % 3 == 0);
      phase++;
    end
  end

  // Monitor: protocol checks every cycle, scoreboard compare on handshake.
  always @(negedge rclk) begin
    if (!reset) begin
      if (fifo_read_en) check("pop_only_when_nonempty", fifo_empty, 1'b0);
      if (rvalid && !rready) check("no_pop_while_stalled", fifo_read_en, 1'b0);
      if (rvalid && rready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got rdata %0h expected no beat", rdata);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("rdata", rdata, b.data);
          check("rid", rid, b.id);
          check("rresp", rresp, b.resp);
          check("rlast", rlast, b.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic feed(input int tag, input int n);
    for (int i = 0; i < n; i++) push_req.push_back(word_of(tag, i));
  endtask

  task automatic send_cmd(input int tag, input logic [IW-1:0] id, input int len, input logic err);
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    check("cmd_ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_len   = LW'(len);
    cmd_err   = err;
    for (int i = 0; i <= len; i++) begin
      beat_t b;
      b.data = word_of(tag, i);
      b.id   = id;
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == len);
      exp_q.push_back(b);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy || rvalid) && n < budget) begin
      tick();
      n++;
    end
    check(name, (exp_q.size() == 0 && !busy && !rvalid), 1'b1);
  endtask

  initial begin
    int base;
    int cnt;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rlast", rlast, 1'b0);
    check("rst_rdata", rdata, '0);
    check("rst_rid", rid, '0);
    check("rst_rresp", rresp, '0);
    check("rst_fifo_read_en", fifo_read_en, 1'b0);
    reset = 1'b0;
    tick();

    // Single beat: word A5A5_0000_0000_0001, id 3
    feed(0, 1);
    tick();
    base = pops;
    send_cmd(0, 4'd3, 0, 1'b0);
    cnt = 0;
    while (!(rvalid && rready) && cnt < 20) begin
      tick();
      cnt++;
    end
    check("single_handshake_seen", (rvalid && rready), 1'b1);
    check("single_rdata_literal", rdata, 64'hA5A5_0000_0000_0001);
    tick();
    tick();
    check("single_cmd_ready_after_hs", cmd_ready, 1'b1);
    wait_done("single_done", 50);
    check("single_pops", pops - base, 1);

    // Streaming: 8 preloaded words, 8 consecutive beats
    feed(1, 8);
    tick();
    tick();
    base = pops;
    send_cmd(1, 4'd7, 7, 1'b0);
    cnt = 0;
    while (!rvalid && cnt < 20) begin
      tick();
      cnt++;
    end
    cnt = 0;
    while (rvalid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("stream_consecutive_beats", cnt, 8);
    wait_done("stream_done", 50);
    check("stream_pops", pops - base, 8);

    // Backpressure: rready 1,0,0 pattern
    feed(2, 4);
    tick();
    rr_mode = 1;
    base = pops;
    send_cmd(2, 4'd9, 3, 1'b0);
    wait_done("bp_done", 100);
    check("bp_pops", pops - base, 4);
    rr_mode = 0;
    tick();

    // Starved FIFO: one word every third cycle
    base = pops;
    send_cmd(3, 4'd1, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      push_req.push_back(word_of(3, i));
      tick();
      tick();
      tick();
    end
    wait_done("starve_done", 50);
    check("starve_pops", pops - base, 4);

    // Error burst at maximum length, then a clean single beat
    feed(4, 256);
    tick();
    tick();
    base = pops;
    send_cmd(4, 4'hA, 255, 1'b1);
    wait_done("err_max_done", 600);
    check("err_max_pops", pops - base, 256);
    feed(5, 1);
    tick();
    send_cmd(5, 4'd5, 0, 1'b0);
    wait_done("after_err_done", 50);

    // Reset mid-burst after the second beat
    feed(6, 6);
    tick();
    tick();
    base = hs_count;
    send_cmd(6, 4'd6, 5, 1'b0);
    cnt = 0;
    while (hs_count < base + 2 && cnt < 30) begin
      tick();
      cnt++;
    end
    check("midrst_two_beats_seen", (hs_count >= base + 2), 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_no_pop_in_reset", fifo_read_en, 1'b0);
    tick();
    check("midrst_rvalid", rvalid, 1'b0);
    check("midrst_rlast", rlast, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    check("midrst_fifo_read_en", fifo_read_en, 1'b0);
    exp_q.delete();
    reset = 1'b0;
    tick();
    tick();
    check("midrst_idle_after", rvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
